// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: next-PC selection, EPC capture and a circular
// return-address stack used to predict return targets.
module pc_sequencer #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'hFFFF_FFFC,
  parameter logic [XLEN-1:0] EXC_VEC   = 32'h8000_0180,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pc_write,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_target,
  input  logic                       exc_valid,
  input  logic [XLEN-1:0]            exc_pc,
  input  logic                       eret,
  input  logic                       ras_push,
  input  logic [XLEN-1:0]            ras_push_addr,
  input  logic                       ras_ret,
  output logic [XLEN-1:0]            pc,
  output logic [XLEN-1:0]            pc_seq,
  output logic [XLEN-1:0]            epc,
  output logic                       pc_redirected,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full
);

  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_ERET,
    SRC_REDIR,
    SRC_RAS,
    SRC_SEQ,
    SRC_HOLD
  } src_e;

  src_e             src;
  logic [XLEN-1:0]  pc_nxt;
  logic [XLEN-1:0]  epc_nxt;
  logic             redir_nxt;
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_nxt;
  logic [CNT_W-1:0] ras_count_nxt;
  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;
  logic [PTR_W-1:0] ras_top_idx;
  logic [XLEN-1:0]  ras_top;
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  assign pc_seq      = pc + XLEN'(INC);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == CNT_MAX);
  assign ras_top_idx = ras_ptr - PTR_W'(1);
  assign ras_top     = ras_mem[ras_top_idx];

  // Next-PC source in fixed priority order
  always_comb begin
    src = SRC_HOLD;
    if (exc_valid)                           src = SRC_EXC;
    else if (eret)                           src = SRC_ERET;
    else if (redirect_valid)                 src = SRC_REDIR;
    else if (ras_ret && pc_write && !ras_empty) src = SRC_RAS;
    else if (pc_write)                       src = SRC_SEQ;
  end

  // PC/EPC update and RAS pointer bookkeeping
  always_comb begin
    pc_nxt        = pc;
    epc_nxt       = epc;
    redir_nxt     = 1'b0;
    ras_ptr_nxt   = ras_ptr;
    ras_count_nxt = ras_count;
    ras_we        = 1'b0;
    ras_widx      = ras_ptr;

    unique case (src)
      SRC_EXC: begin
        pc_nxt    = EXC_VEC;
        epc_nxt   = exc_pc;
        redir_nxt = 1'b1;
      end
      SRC_ERET: begin
        pc_nxt    = epc;
        redir_nxt = 1'b1;
      end
      SRC_REDIR: begin
        pc_nxt    = redirect_target;
        redir_nxt = 1'b1;
      end
      SRC_RAS: begin
        pc_nxt    = ras_top;
        redir_nxt = 1'b1;
      end
      SRC_SEQ:  pc_nxt = pc_seq;
      default:  pc_nxt = pc;
    endcase

    if (src == SRC_EXC) begin
      ras_ptr_nxt   = '0;
      ras_count_nxt = '0;
    end else if (src == SRC_RAS) begin
      // A simultaneous call replaces the popped entry in place
      if (ras_push) begin
        ras_we   = 1'b1;
        ras_widx = ras_top_idx;
      end else begin
        ras_ptr_nxt   = ras_top_idx;
        ras_count_nxt = ras_count - CNT_W'(1);
      end
    end else if (ras_push) begin
      ras_we      = 1'b1;
      ras_ptr_nxt = ras_ptr + PTR_W'(1);
      if (!ras_full) ras_count_nxt = ras_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_VEC;
      epc           <= '0;
      pc_redirected <= 1'b0;
      ras_ptr       <= '0;
      ras_count     <= '0;
    end else begin
      pc            <= pc_nxt;
      epc           <= epc_nxt;
      pc_redirected <= redir_nxt;
      ras_ptr       <= ras_ptr_nxt;
      ras_count     <= ras_count_nxt;
    end
  end

  // RAS storage needs no reset; only entries counted by ras_count are ever read
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_widx] <= ras_push_addr;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus queues expected state,
// an independent monitor samples the DUT after each clock or reset edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        eret;
  logic        ras_push;
  logic [31:0] ras_push_addr;
  logic        ras_ret;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] epc;
  logic        pc_redirected;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .eret           (eret),
    .ras_push       (ras_push),
    .ras_push_addr  (ras_push_addr),
    .ras_ret        (ras_ret),
    .pc             (pc),
    .pc_seq         (pc_seq),
    .epc            (epc),
    .pc_redirected  (pc_redirected),
    .ras_count      (ras_count),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        red;
    logic [2:0]  cnt;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation is consumed per clock or reset edge
  always begin
    exp_t e;
    @(posedge clk or negedge rst_n);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.nm, "pc", pc, e.pc);
      chk(e.nm, "pc_seq", pc_seq, e.pc + 32'd4);
      chk(e.nm, "pc_redirected", 32'(pc_redirected), 32'(e.red));
      chk(e.nm, "ras_count", 32'(ras_count), 32'(e.cnt));
      chk(e.nm, "ras_empty", 32'(ras_empty), 32'(e.cnt == 3'd0));
      chk(e.nm, "ras_full", 32'(ras_full), 32'(e.cnt == 3'd4));
      chk(e.nm, "epc", epc, e.epc);
    end
  end

  task automatic expect_state(input string nm, input logic [31:0] e_pc, input logic e_red,
                              input int e_cnt, input logic [31:0] e_epc);
    exp_t e;
    e.nm  = nm;
    e.pc  = e_pc;
    e.red = e_red;
    e.cnt = 3'(e_cnt);
    e.epc = e_epc;
    sb.push_back(e);
  endtask

  // Queue expectation for the coming edge, clock once, then clear pulse inputs
  task automatic step(input string nm, input logic [31:0] e_pc, input logic e_red,
                      input int e_cnt, input logic [31:0] e_epc);
    expect_state(nm, e_pc, e_red, e_cnt, e_epc);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    exc_valid      = 1'b0;
    eret           = 1'b0;
    ras_push       = 1'b0;
    ras_ret        = 1'b0;
  endtask

  task automatic push(input logic [31:0] a);
    ras_push      = 1'b1;
    ras_push_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    exc_valid = 1'b0; exc_pc = '0; eret = 1'b0;
    ras_push = 1'b0; ras_push_addr = '0; ras_ret = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    step("reset", 32'hFFFF_FFFC, 1'b0, 0, 32'h0);
    rst_n = 1'b1;

    pc_write = 1'b1;
    step("seq0", 32'h0000_0000, 1'b0, 0, 32'h0);
    step("seq1", 32'h0000_0004, 1'b0, 0, 32'h0);
    step("seq2", 32'h0000_0008, 1'b0, 0, 32'h0);

    // Asynchronous reset between clock edges
    expect_state("async_rst", 32'hFFFF_FFFC, 1'b0, 0, 32'h0);
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    step("run0", 32'h00, 1'b0, 0, 32'h0);
    step("run1", 32'h04, 1'b0, 0, 32'h0);
    step("run2", 32'h08, 1'b0, 0, 32'h0);
    step("run3", 32'h0C, 1'b0, 0, 32'h0);
    step("run4", 32'h10, 1'b0, 0, 32'h0);

    pc_write = 1'b0;
    step("stall0", 32'h10, 1'b0, 0, 32'h0);
    step("stall1", 32'h10, 1'b0, 0, 32'h0);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step("redir_stall", 32'h40, 1'b1, 0, 32'h0);
    step("redir_after", 32'h40, 1'b0, 0, 32'h0);

    push(32'h50);
    step("pre_exc_push", 32'h40, 1'b0, 1, 32'h0);
    exc_valid = 1'b1; exc_pc = 32'h24;
    redirect_valid = 1'b1; redirect_target = 32'h40;
    ras_ret = 1'b1; pc_write = 1'b1;
    step("exc", 32'h8000_0180, 1'b1, 0, 32'h24);
    pc_write = 1'b0;
    eret = 1'b1;
    step("eret", 32'h24, 1'b1, 0, 32'h24);

    push(32'h100); step("push100", 32'h24, 1'b0, 1, 32'h24);
    push(32'h104); step("push104", 32'h24, 1'b0, 2, 32'h24);
    push(32'h108); step("push108", 32'h24, 1'b0, 3, 32'h24);
    push(32'h10C); step("push10C", 32'h24, 1'b0, 4, 32'h24);
    push(32'h110); step("push110_ovf", 32'h24, 1'b0, 4, 32'h24);
    pc_write = 1'b1;
    ras_ret = 1'b1; step("ret110", 32'h110, 1'b1, 3, 32'h24);
    ras_ret = 1'b1; step("ret10C", 32'h10C, 1'b1, 2, 32'h24);
    ras_ret = 1'b1; step("ret108", 32'h108, 1'b1, 1, 32'h24);
    ras_ret = 1'b1; step("ret104", 32'h104, 1'b1, 0, 32'h24);
    ras_ret = 1'b1; step("ret_empty", 32'h108, 1'b0, 0, 32'h24);

    pc_write = 1'b0;
    push(32'h200); step("push200", 32'h108, 1'b0, 1, 32'h24);
    push(32'h300); step("push300", 32'h108, 1'b0, 2, 32'h24);
    pc_write = 1'b1;
    push(32'h400); ras_ret = 1'b1;
    step("push_pop", 32'h300, 1'b1, 2, 32'h24);
    ras_ret = 1'b1; step("ret400", 32'h400, 1'b1, 1, 32'h24);
    ras_ret = 1'b1; step("ret200", 32'h200, 1'b1, 0, 32'h24);

    pc_write = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step("to_top", 32'hFFFF_FFFC, 1'b1, 0, 32'h24);
    pc_write = 1'b1;
    step("wrap", 32'h0000_0000, 1'b0, 0, 32'h24);

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
